// File: rtl/lut_mult_sequencer_pkg.sv
// Shared definitions for the LUT multiplier sequencer: FSM encoding, digit-index
// type, shift table and wait-counter sizing helpers.
package lut_mult_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int K_W       = 2;
  localparam int N_LOOKUPS = 4;

  typedef logic [K_W-1:0] k_t;

  // Shift in units of W: k0 -> 0, k1/k2 -> 1, k3 -> 2 (sum of the digit half selects).
  function automatic logic [1:0] shift_sel(input k_t k);
    return {1'b0, k[1]} + {1'b0, k[0]};
  endfunction

  // Lookups strictly after k; used to find the next lookup still to issue.
  function automatic logic [N_LOOKUPS-1:0] above_mask(input k_t k);
    logic [N_LOOKUPS-1:0] m;
    case (k)
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Lowest set bit of m as {found, index}.
  function automatic logic [K_W:0] first_set(input logic [N_LOOKUPS-1:0] m);
    logic [K_W:0] r;
    r = '0;
    for (int i = N_LOOKUPS - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, k_t'(i)};
    end
    return r;
  endfunction

  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/lut_mult_acc.sv
// 4W shift-and-add accumulator: synchronous clear, shift select in units of W,
// add enable. Holds the running product of the digit lookups.
module lut_mult_acc #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           add_en,
  input  logic [1:0]     shift_sel,
  input  logic [2*W-1:0] data,
  output logic [4*W-1:0] acc
);

  logic [4*W-1:0] addend;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    addend = '0;
    case (shift_sel)
      2'd0:    addend = {{(2*W){1'b0}}, data};
      2'd1:    addend = {{W{1'b0}}, data, {W{1'b0}}};
      default: addend = {data, {(2*W){1'b0}}};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/lut_mult_sequencer.sv
// Drives a W x W product ROM through four digit lookups to form a 2W x 2W product.
// Optional ZERO_SKIP_EN: lookups with a zero digit are skipped entirely.
module lut_mult_sequencer
  import lut_mult_sequencer_pkg::*;
#(
  parameter int W      = 4,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_a,
  input  logic [2*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_product,
  output logic           busy,
  output logic [2*W-1:0] rom_address,
  output logic           rom_read_en,
  output logic           rom_ce,
  input  logic [2*W-1:0] rom_data
);

  localparam int CNT_W = cnt_width(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  state_e               state_q, state_d;
  logic [2*W-1:0]       a_q, b_q;
  k_t                   k_q, k_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 latch_ops;
  logic                 acc_clr, acc_add;
  logic [4*W-1:0]       acc;
  logic [N_LOOKUPS-1:0] mask_in, mask_cur;
  logic [K_W:0]         pick_first, pick_next;
  logic [W-1:0]         a_dig, b_dig;

`ifdef ZERO_SKIP_EN
  // Bit k set when lookup k has both digits non-zero and so contributes to the product.
  function automatic logic [N_LOOKUPS-1:0] digit_mask(input logic [2*W-1:0] a,
                                                      input logic [2*W-1:0] b);
    logic al, ah, bl, bh;
    al = |a[W-1:0];
    ah = |a[2*W-1:W];
    bl = |b[W-1:0];
    bh = |b[2*W-1:W];
    return {ah & bh, ah & bl, al & bh, al & bl};
  endfunction

  assign mask_in  = digit_mask(in_a, in_b);
  assign mask_cur = digit_mask(a_q, b_q);
`else
  assign mask_in  = '1;
  assign mask_cur = '1;
`endif

  assign pick_first = first_set(mask_in);
  assign pick_next  = first_set(mask_cur & above_mask(k_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    latch_ops = 1'b0;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          latch_ops = 1'b1;
          acc_clr   = 1'b1;
          cnt_d     = '0;
          if (pick_first[K_W]) begin
            state_d = ST_LOOKUP;
            k_d     = pick_first[K_W-1:0];
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOOKUP: begin
        if (cnt_q == CNT_LAST) begin
          acc_add = 1'b1;
          cnt_d   = '0;
          if (pick_next[K_W]) k_d = pick_next[K_W-1:0];
          else                state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (latch_ops) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      k_q   <= k_d;
      cnt_q <= cnt_d;
    end
  end

  // Digit order: k[1] selects the a half, k[0] the b half.
  assign a_dig = k_q[1] ? a_q[2*W-1:W] : a_q[W-1:0];
  assign b_dig = k_q[0] ? b_q[2*W-1:W] : b_q[W-1:0];

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    rom_read_en = (state_q == ST_LOOKUP);
    rom_ce      = (state_q == ST_LOOKUP);
    rom_address = '0;
    out_product = '0;
    if (state_q == ST_LOOKUP) rom_address = {a_dig, b_dig};
    if (state_q == ST_DONE)   out_product = acc;
  end

  lut_mult_acc #(.W(W)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .add_en    (acc_add),
    .shift_sel (shift_sel(k_q)),
    .data      (rom_data),
    .acc       (acc)
  );

endmodule
